// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Definitions shared by the traffic light FSM and the traffic_timer block.
//   LIGHT_STATE_WIDTH : width of the one-hot phase select bus
//   GREEN_IDX / YELLOW_IDX / RED_IDX : bit position of each phase in that bus
//   phase_e / decode_phase() : turn the one-hot select into a phase; anything
//                              that is not exactly one known bit is PHASE_NONE
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int LIGHT_STATE_WIDTH = 3;

    localparam int GREEN_IDX  = 0;
    localparam int YELLOW_IDX = 1;
    localparam int RED_IDX    = 2;

    localparam logic [LIGHT_STATE_WIDTH-1:0] GREEN_ONEHOT  = LIGHT_STATE_WIDTH'(1 << GREEN_IDX);
    localparam logic [LIGHT_STATE_WIDTH-1:0] YELLOW_ONEHOT = LIGHT_STATE_WIDTH'(1 << YELLOW_IDX);
    localparam logic [LIGHT_STATE_WIDTH-1:0] RED_ONEHOT    = LIGHT_STATE_WIDTH'(1 << RED_IDX);

    typedef enum logic [1:0] {
        PHASE_NONE,
        PHASE_GREEN,
        PHASE_YELLOW,
        PHASE_RED
    } phase_e;

    // 000 (FSM idle) and every multi-hot pattern map to PHASE_NONE.
    function automatic phase_e decode_phase(input logic [LIGHT_STATE_WIDTH-1:0] init);
        phase_e phase;
        case (init)
            GREEN_ONEHOT:  phase = PHASE_GREEN;
            YELLOW_ONEHOT: phase = PHASE_YELLOW;
            RED_ONEHOT:    phase = PHASE_RED;
            default:       phase = PHASE_NONE;
        endcase
        return phase;
    endfunction

endpackage

// File: rtl/traffic_timer_sec_prescaler.sv
// -----------------------------------------------------------------------------
// sec_prescaler
// Clock-to-second prescaler. sec_cnt runs 0..CLK_PER_SEC-1 and wraps while
// enabled; dropping the enable clears it at the next edge.
// Parameters:
//   CLK_PER_SEC : clk cycles per second (>= 2)
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   i_en       in   run enable; low clears the counter synchronously
//   o_pre_last out  high while sec_cnt == CLK_PER_SEC-2
//   o_tick     out  high while sec_cnt == CLK_PER_SEC-1 (the wrap cycle)
// -----------------------------------------------------------------------------
module sec_prescaler #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_pre_last,
    output logic o_tick
);

    localparam int SEC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    localparam logic [SEC_W-1:0] SEC_LAST     = SEC_W'(CLK_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_PRE_LAST = SEC_W'(CLK_PER_SEC - 2);

    logic [SEC_W-1:0] r_sec_cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register in the design samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_cnt <= '0;
        end else if (!i_en) begin
            r_sec_cnt <= '0;
        end else if (r_sec_cnt == SEC_LAST) begin
            r_sec_cnt <= '0;
        end else begin
            r_sec_cnt <= r_sec_cnt + SEC_W'(1);
        end
    end

    // Pure decodes of the register: no input reaches these combinationally.
    assign o_pre_last = (r_sec_cnt == SEC_PRE_LAST);
    assign o_tick     = (r_sec_cnt == SEC_LAST);

endmodule

// File: rtl/traffic_timer.sv
// -----------------------------------------------------------------------------
// traffic_timer
// Timing stage in front of the traffic light FSM: a seconds prescaler plus a
// per-phase seconds down-counter. The FSM advances on
// second_cnt_pre_last & light_cnt_last, so its new one-hot light_cnt_init is
// visible during the sec_tick cycle and is loaded on the following wrap edge.
// Parameters:
//   CLK_PER_SEC : clk cycles per second (>= 2)
//   GREEN_SEC / YELLOW_SEC / RED_SEC : phase durations in seconds (>= 1)
//   CNT_WIDTH   : seconds counter width (every duration <= 2**CNT_WIDTH)
// Ports:
//   clk                  in   clock
//   rst_n                in   asynchronous active-low reset
//   en                   in   run enable shared with the FSM; low clears both
//                             counters at the next edge
//   light_cnt_init [2:0] in   one-hot phase select (bit0 green, bit1 yellow,
//                             bit2 red); sampled only on the wrap edge
//   second_cnt_pre_last  out  high one cycle before each sec_tick
//   light_cnt_last       out  high while the seconds counter is 0
//   sec_tick             out  high during the prescaler wrap cycle
// Optional build macro TRAFFIC_TIMER_COUNTDOWN_EN adds:
//   remain_sec [CNT_WIDTH:0] out  seconds left in the current phase
//                             (light_cnt+1) for the pedestrian display, 0 when
//                             light_cnt_init is not one-hot
// -----------------------------------------------------------------------------
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int GREEN_SEC   = 30,
    parameter int YELLOW_SEC  = 3,
    parameter int RED_SEC     = 20,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
    output logic                         second_cnt_pre_last,
    output logic                         light_cnt_last,
    output logic                         sec_tick
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
    ,
    output logic [CNT_WIDTH:0]           remain_sec
`endif
);

    // Reload values are duration-1 because the zero second is also counted;
    // they are truncated to the counter width.
    localparam logic [CNT_WIDTH-1:0] GREEN_RLD  = CNT_WIDTH'(GREEN_SEC - 1);
    localparam logic [CNT_WIDTH-1:0] YELLOW_RLD = CNT_WIDTH'(YELLOW_SEC - 1);
    localparam logic [CNT_WIDTH-1:0] RED_RLD    = CNT_WIDTH'(RED_SEC - 1);

    logic                 w_pre_last;
    logic                 w_tick;
    logic [CNT_WIDTH-1:0] w_reload;
    logic [CNT_WIDTH-1:0] r_light_cnt;

    sec_prescaler #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_sec_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .o_pre_last (w_pre_last),
        .o_tick     (w_tick)
    );

    // Idle (000) and malformed selects reload 0, which keeps light_cnt_last
    // high so the FSM can leave idle at the next pre-last cycle.
    always_comb begin
        // NOTE: default assignment first so no branch leaves w_reload
        // unassigned, which would otherwise infer a latch.
        w_reload = '0;
        case (decode_phase(light_cnt_init))
            PHASE_GREEN:  w_reload = GREEN_RLD;
            PHASE_YELLOW: w_reload = YELLOW_RLD;
            PHASE_RED:    w_reload = RED_RLD;
            default:      w_reload = '0;
        endcase
    end

    // The counter only moves on the wrap edge; zero reloads instead of
    // decrementing, so it can never underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_light_cnt <= '0;
        end else if (!en) begin
            r_light_cnt <= '0;
        end else if (w_tick) begin
            if (r_light_cnt != '0) begin
                r_light_cnt <= r_light_cnt - CNT_WIDTH'(1);
            end else begin
                r_light_cnt <= w_reload;
            end
        end
    end

    assign second_cnt_pre_last = w_pre_last;
    assign light_cnt_last      = (r_light_cnt == '0);
    assign sec_tick            = w_tick;

`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
    localparam int REM_W = CNT_WIDTH + 1;

    // One extra bit so a full 2**CNT_WIDTH-second phase still displays.
    assign remain_sec = (decode_phase(light_cnt_init) != PHASE_NONE)
                      ? REM_W'(r_light_cnt) + REM_W'(1)
                      : '0;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// -----------------------------------------------------------------------------
// tb_traffic_timer
// Self-checking bench for traffic_timer with CLK_PER_SEC=4, GREEN_SEC=3,
// YELLOW_SEC=1, RED_SEC=2, CNT_WIDTH=8. A cycle-by-cycle vector table covers
// the open-loop behaviour; hand-written sequences cover async reset and the
// closed loop with a small light FSM model. Honors TRAFFIC_TIMER_COUNTDOWN_EN.
// -----------------------------------------------------------------------------
module tb_traffic_timer;
    import traffic_pkg::*;

    localparam int CPS = 4;
    localparam int GS  = 3;
    localparam int YS  = 1;
    localparam int RS  = 2;
    localparam int CW  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] light_cnt_init;
    logic       pre_last;
    logic       last;
    logic       tick;
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
    logic [CW:0] remain_sec;
`endif

    always #5 clk = ~clk;

    traffic_timer #(
        .CLK_PER_SEC (CPS),
        .GREEN_SEC   (GS),
        .YELLOW_SEC  (YS),
        .RED_SEC     (RS),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .light_cnt_init      (light_cnt_init),
        .second_cnt_pre_last (pre_last),
        .light_cnt_last      (last),
        .sec_tick            (tick)
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
        ,
        .remain_sec          (remain_sec)
`endif
    );

    typedef struct {
        logic       en;
        logic [2:0] init;
        logic       pre;
        logic       last;
        logic       tick;
        int         remain;
    } vec_t;

    typedef enum {S_IDLE, S_GREEN, S_YELLOW, S_RED} fsm_e;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   exp_len_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic add(input logic e, input logic [2:0] i, input logic p,
                       input logic l, input logic t, input int r);
        vec_t v;
        v.en = e; v.init = i; v.pre = p; v.last = l; v.tick = t; v.remain = r;
        vecs.push_back(v);
    endtask

    function automatic logic [2:0] onehot(input fsm_e s);
        case (s)
            S_GREEN:  return 3'(1 << GREEN_IDX);
            S_YELLOW: return 3'(1 << YELLOW_IDX);
            S_RED:    return 3'(1 << RED_IDX);
            default:  return 3'b000;
        endcase
    endfunction

    function automatic fsm_e next_state(input fsm_e s);
        case (s)
            S_GREEN:  return S_YELLOW;
            S_YELLOW: return S_RED;
            default:  return S_GREEN;
        endcase
    endfunction

    function automatic int phase_len(input fsm_e s);
        case (s)
            S_GREEN:  return GS * CPS;
            S_YELLOW: return YS * CPS;
            default:  return RS * CPS;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  exp_v;
        fsm_e  state;
        bit    adv;
        int    len;
        int    done;
        int    budget;
        bit    found;

        // Columns: en, init, exp pre_last, exp last, exp tick, exp remain_sec.
        // Idle select: prescaler free-runs, last stays high.
        add(1, 3'b000, 0, 1, 0, 0); add(1, 3'b000, 1, 1, 0, 0);
        add(1, 3'b000, 0, 1, 1, 0); add(1, 3'b000, 0, 1, 0, 0);
        add(1, 3'b000, 0, 1, 0, 0); add(1, 3'b000, 1, 1, 0, 0);
        add(1, 3'b000, 0, 1, 1, 0);
        // Green loaded at wrap: light_cnt 2,2,2,2,1,1,1,1,0...
        add(1, 3'b001, 0, 0, 0, 3); add(1, 3'b001, 0, 0, 0, 3);
        add(1, 3'b001, 1, 0, 0, 3); add(1, 3'b001, 0, 0, 1, 3);
        add(1, 3'b001, 0, 0, 0, 2); add(1, 3'b001, 0, 0, 0, 2);
        add(1, 3'b001, 1, 0, 0, 2); add(1, 3'b001, 0, 0, 1, 2);
        add(1, 3'b001, 0, 1, 0, 1);
        // Red select away from the wrap edge must be ignored.
        add(1, 3'b100, 0, 1, 0, 1); add(1, 3'b100, 1, 1, 0, 1);
        add(1, 3'b100, 0, 1, 1, 1);
        // Yellow at wrap reloads 0.
        add(1, 3'b010, 0, 1, 0, 1); add(1, 3'b010, 0, 1, 0, 1);
        add(1, 3'b010, 1, 1, 0, 1); add(1, 3'b010, 0, 1, 1, 1);
        // Multi-hot select behaves as idle.
        add(1, 3'b011, 0, 1, 0, 0); add(1, 3'b011, 0, 1, 0, 0);
        add(1, 3'b011, 1, 1, 0, 0); add(1, 3'b011, 0, 1, 1, 0);
        // Green again, then en dropped at light_cnt=1, sec_cnt=2.
        add(1, 3'b001, 0, 0, 0, 3); add(1, 3'b001, 0, 0, 0, 3);
        add(1, 3'b001, 1, 0, 0, 3); add(1, 3'b001, 0, 0, 1, 3);
        add(1, 3'b001, 0, 0, 0, 2); add(1, 3'b001, 0, 0, 0, 2);
        add(1, 3'b001, 1, 0, 0, 2);
        add(0, 3'b000, 0, 1, 0, 0); add(0, 3'b000, 0, 1, 0, 0);
        // Re-enabled: pre_last two edges later.
        add(1, 3'b000, 0, 1, 0, 0); add(1, 3'b000, 1, 1, 0, 0);
        add(1, 3'b000, 0, 1, 1, 0); add(1, 3'b000, 0, 1, 0, 0);

        // Reset state, with clocks running under reset.
        rst_n = 1'b0;
        en = 1'b1;
        light_cnt_init = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset.pre_last", int'(pre_last), 0);
        check("reset.last", int'(last), 1);
        check("reset.tick", int'(tick), 0);
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
        check("reset.remain", int'(remain_sec), 0);
`endif
        #2 rst_n = 1'b1;

        foreach (vecs[i]) begin
            en = vecs[i].en;
            light_cnt_init = vecs[i].init;
            sb_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            check($sformatf("vec%0d.pre_last", i), int'(pre_last), int'(exp_v.pre));
            check($sformatf("vec%0d.last", i), int'(last), int'(exp_v.last));
            check($sformatf("vec%0d.tick", i), int'(tick), int'(exp_v.tick));
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
            check($sformatf("vec%0d.remain", i), int'(remain_sec), exp_v.remain);
`endif
        end

        // Closed loop with a registered light FSM: clear via en, start idle.
        en = 1'b0;
        light_cnt_init = 3'b000;
        @(posedge clk);
        #1;
        en = 1'b1;
        state = S_IDLE;
        len = 0;
        done = 0;
        budget = 0;
        while (done < 6 && budget < 150) begin
            adv = pre_last & last;
            @(posedge clk);
            #1;
            budget++;
            if (adv) begin
                if (state != S_IDLE) begin
                    if (exp_len_q.size() == 0) begin
                        check("loop.scoreboard_empty", 1, 0);
                    end else begin
                        check($sformatf("loop.phase%0d_len", done), len, exp_len_q.pop_front());
                    end
                    done++;
                end
                state = next_state(state);
                exp_len_q.push_back(phase_len(state));
                len = 0;
            end
            light_cnt_init = onehot(state);
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
            if (state == S_GREEN && (len == 1 || len == 5 || len == 9)) begin
                check($sformatf("loop.remain_at_%0d", len), int'(remain_sec),
                      (len == 1) ? 3 : (len == 5) ? 2 : 1);
            end
`endif
            len++;
        end
        check("loop.phases_completed", done, 6);

        // Asynchronous reset mid-phase: find sec_cnt=2 with light_cnt>0.
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (pre_last && !last) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("areset.found_mid_phase", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset.pre_last", int'(pre_last), 0);
        check("areset.last", int'(last), 1);
        check("areset.tick", int'(tick), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        en = 1'b1;
        light_cnt_init = 3'b000;
        @(posedge clk);
        #1;
        check("areset.restart1_pre_last", int'(pre_last), 0);
        @(posedge clk);
        #1;
        check("areset.restart2_pre_last", int'(pre_last), 1);
        check("areset.restart2_last", int'(last), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/traffic_timer.md
# traffic_timer

Timing stage directly upstream of the traffic light FSM: a clock-to-second prescaler plus a per-phase seconds down-counter. It consumes the FSM's one-hot `light_cnt_init` to select the phase duration, and produces `second_cnt_pre_last` and `light_cnt_last`. The FSM ANDs these two strobes to advance GREEN→YELLOW→RED→GREEN.

## Interface
- `CLK_PER_SEC`, default 50_000_000: clk cycles per second; must be ≥2.
- `GREEN_SEC`, default 30: green duration in seconds; must be ≥1.
- `YELLOW_SEC`, default 3: yellow duration in seconds; must be ≥1.
- `RED_SEC`, default 20: red duration in seconds; must be ≥1.
- `CNT_WIDTH`, default 8: seconds counter width; every duration must be ≤2**CNT_WIDTH.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run enable, shared with the FSM; low → synchronous clear.
- `light_cnt_init`  in  3  one-hot phase select; bit0 green, bit1 yellow, bit2 red.
- `second_cnt_pre_last`  out  1  high while `sec_cnt == CLK_PER_SEC-2`.
- `light_cnt_last`  out  1  high while `light_cnt == 0`.
- `sec_tick`  out  1  high while `sec_cnt == CLK_PER_SEC-1`, i.e. the wrap cycle.

## Operation
- `sec_cnt` uses `$clog2(CLK_PER_SEC)` bits and counts 0..CLK_PER_SEC-1, then wraps to 0 whenever `en`=1.
- `light_cnt` uses CNT_WIDTH bits and updates only on the wrap edge, i.e. when `sec_tick`=1 and `en`=1:
  - If `light_cnt`≠0, it decrements.
  - If `light_cnt`==0, it reloads from `light_cnt_init`: 001→GREEN_SEC-1, 010→YELLOW_SEC-1, 100→RED_SEC-1, any other value (000 or not one-hot)→0.
- `light_cnt_init` is sampled only on the wrap edge. Changes at any other time are ignored.
- When `init`=000 (FSM IDLE), the block reloads 0, so `light_cnt_last` stays high and the FSM leaves IDLE at the next pre-last cycle.
- `en`=0: at the next edge `sec_cnt`←0 and `light_cnt`←0. Both counters hold there while `en` stays low.
- When `en` rises, counting restarts from `sec_cnt`=0.
- Reset values: `sec_cnt`=0, `light_cnt`=0. Resulting outputs: `second_cnt_pre_last`=0 (1 only if CLK_PER_SEC==2), `light_cnt_last`=1, `sec_tick`=0 (1 only if CLK_PER_SEC==1, which is disallowed).
- Reset asserted mid-phase: counters clear immediately (asynchronous), with no pending state retained.
- Arithmetic: decrement never underflows, because the zero value always reloads instead. Reload constants are truncated to CNT_WIDTH.

## Timing
- All outputs are combinational decodes of the two registers. There is no input-to-output combinational path.
- The FSM registers on the `pre_last & last` edge, so the new `light_cnt_init` is visible during the `sec_tick` cycle and is loaded at the wrap edge. Handoff latency is 1 cycle.
- Phase length seen at the FSM `light` output is exactly DURATION_SEC×CLK_PER_SEC cycles.
- `sec_tick` period is CLK_PER_SEC cycles. `second_cnt_pre_last` leads `sec_tick` by exactly 1 cycle.

## Configuration
- `TRAFFIC_TIMER_COUNTDOWN_EN` defined:
  - Adds output port `remain_sec` [CNT_WIDTH:0], equal to `light_cnt`+1 while `light_cnt_init` is one-hot, else 0. It is used for the pedestrian display.
  - Reset value is 0.
- Undefined: the port and its logic are absent. Functionality is otherwise identical.

## Structure
- Shared package `traffic_pkg`:
  - `LIGHT_STATE_WIDTH`=3.
  - Phase index constants `GREEN_IDX`=0, `YELLOW_IDX`=1, `RED_IDX`=2, used by both this block and the FSM.
- One sub-module, `sec_prescaler`:
  - Contains `sec_cnt`, and produces `pre_last` and `tick`.
  - `traffic_timer` instantiates it and holds `light_cnt` plus the reload mux.

## Test plan
Bench settings: CLK_PER_SEC=4, GREEN_SEC=3, YELLOW_SEC=1, RED_SEC=2, CNT_WIDTH=8.
1. Reset release, `en`=1, `init`=000 → `sec_cnt` sequence 0,1,2,3,0…; `pre_last` high every 4th cycle at `sec_cnt`=2; `light_cnt_last` constantly 1.
2. `init`=001 held through a wrap edge → `light_cnt`=2,2,2,2,1×4,0×4; `last` rises 8 cycles after the load; `pre_last&last` first coincide 10 cycles after the load.
3. `init`=010 at wrap → reload 0; `last` stays 1; next `pre_last&last` occurs 3 cycles later.
4. `init`=011 at wrap → treated as 000, loads 0; `last`=1.
5. `en` dropped while `light_cnt`=1, `sec_cnt`=2 → next edge `sec_cnt`=0, `light_cnt`=0, `pre_last`=0, `last`=1; `en` re-raised → `pre_last` after 2 cycles.
6. Closed loop with the light FSM stage, `en`=1 → green 12 cycles, yellow 4 cycles, red 8 cycles, repeating; with `TRAFFIC_TIMER_COUNTDOWN_EN`, `remain_sec` reads 3,2,1 across green.
